// File: rtl/dpot_sweep_gen_pkg.sv
// Shared encodings for the DPOT sweep generator: waveform modes, FSM states,
// ramp direction and the default dwell-counter width.
package dpot_sweep_gen_pkg;

  localparam int unsigned HOLD_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SAW_UP  = 2'd0,
    MODE_SAW_DN  = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_XFER = 3'd3,
    ST_HOLD = 3'd4,
    ST_STEP = 3'd5
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/dpot_next_code.sv
// Combinational next-code rule for the sweep: given the current code, step,
// bounds, direction and mode, produce the next code, direction and wrap flag.
module dpot_next_code
  import dpot_sweep_gen_pkg::*;
(
  input  logic [7:0] v,
  input  logic [7:0] s,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  dir_e       dir,
  input  mode_e      mode,
  output logic [7:0] v_next,
  output dir_e       dir_next,
  output logic       wrap
);

  // 9-bit sums so that v+s and lo+s never wrap at 255
  logic [8:0] up_sum;
  logic [8:0] lo_sum;

  always_comb begin
    up_sum   = {1'b0, v} + {1'b0, s};
    lo_sum   = {1'b0, lo} + {1'b0, s};
    v_next   = v;
    dir_next = dir;
    wrap     = 1'b0;
    case (mode)
      MODE_SAW_UP: begin
        if (up_sum > {1'b0, hi}) begin
          v_next = lo;
          wrap   = 1'b1;
        end else begin
          v_next = up_sum[7:0];
        end
      end
      MODE_ONESHOT: begin
        v_next = (up_sum > {1'b0, hi}) ? hi : up_sum[7:0];
      end
      MODE_SAW_DN: begin
        if ({1'b0, v} < lo_sum) begin
          v_next = hi;
          wrap   = 1'b1;
        end else begin
          v_next = v - s;
        end
      end
      MODE_TRI: begin
        // clamping at both ends guarantees lo and hi are always emitted
        if (dir == DIR_UP) begin
          if (up_sum >= {1'b0, hi}) begin
            v_next   = hi;
            dir_next = DIR_DN;
          end else begin
            v_next = up_sum[7:0];
          end
        end else begin
          if ({1'b0, v} <= lo_sum) begin
            v_next   = lo;
            dir_next = DIR_UP;
            wrap     = 1'b1;
          end else begin
            v_next = v - s;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dpot_sweep_gen.sv
// Wiper-code sweep generator feeding the Pmod DPOT SPI interface through its
// update/ready handshake; runs entirely in the SCLK domain.
module dpot_sweep_gen
  import dpot_sweep_gen_pkg::*;
#(
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              SCLK,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [7:0]        lo,
  input  logic [7:0]        hi,
  input  logic [7:0]        step,
  input  logic [HOLD_W-1:0] hold,
  input  logic              ready,
  output logic [7:0]        value,
  output logic              update,
  output logic              busy,
  output logic              period,
  output logic              done,
  output logic              cfg_err
);

  state_e            state;
  state_e            state_next;
  mode_e             mode_r;
  logic [7:0]        lo_r;
  logic [7:0]        hi_r;
  logic [7:0]        s_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] cnt;
  dir_e              dir;
  logic              en_q;

  logic [7:0]        nv;
  dir_e              nd;
  logic              nwrap;
  logic              start;
  logic              bad_cfg;

  dpot_next_code u_next (
    .v        (value),
    .s        (s_r),
    .lo       (lo_r),
    .hi       (hi_r),
    .dir      (dir),
    .mode     (mode_r),
    .v_next   (nv),
    .dir_next (nd),
    .wrap     (nwrap)
  );

  // After a one-shot finish or a bad config, enable must be seen low before
  // restarting; otherwise a held-high enable would loop through LOAD forever.
  assign start   = enable && (!(done || cfg_err) || !en_q);
  assign bad_cfg = (lo > hi);

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = bad_cfg ? ST_IDLE : ST_REQ;
      ST_REQ:  if (!ready) state_next = ST_XFER;
      ST_XFER: begin
        if (ready) begin
          if (!enable)
            state_next = ST_IDLE;
          else if (mode_r == MODE_ONESHOT && value == hi_r)
            state_next = ST_IDLE;
          else
            state_next = ST_HOLD;
        end
      end
      ST_HOLD: if (cnt == '0) state_next = ST_STEP;
      ST_STEP: state_next = ST_REQ;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      value   <= '0;
      update  <= 1'b0;
      period  <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      dir     <= DIR_UP;
      cnt     <= '0;
      en_q    <= 1'b0;
      mode_r  <= MODE_SAW_UP;
      lo_r    <= '0;
      hi_r    <= '0;
      s_r     <= 8'd1;
      hold_r  <= '0;
    end else begin
      en_q   <= enable;
      update <= (state_next == ST_REQ);
      period <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (state_next == ST_LOAD) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          mode_r <= mode_e'(mode);
          lo_r   <= lo;
          hi_r   <= hi;
          s_r    <= (step == '0) ? 8'd1 : step;
          hold_r <= hold;
          if (bad_cfg) begin
            cfg_err <= 1'b1;
          end else begin
            value <= (mode == MODE_SAW_DN) ? hi : lo;
            dir   <= (mode == MODE_SAW_DN) ? DIR_DN : DIR_UP;
          end
        end
        ST_XFER: begin
          if (ready) begin
            if (enable && mode_r == MODE_ONESHOT && value == hi_r) done <= 1'b1;
            cnt <= hold_r;
          end
        end
        ST_HOLD: begin
          if (cnt != '0) cnt <= cnt - HOLD_W'(1);
        end
        ST_STEP: begin
          value  <= nv;
          dir    <= nd;
          period <= nwrap;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpot_sweep_gen.sv
// Directed bench for dpot_sweep_gen: a simple DPOT-interface ready model plus
// a negedge monitor that records {period, value} at every update rise.
module tb_dpot_sweep_gen;

  logic        SCLK = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic [7:0]  step;
  logic [15:0] hold;
  logic        ready;
  logic [7:0]  value;
  logic        update;
  logic        busy;
  logic        period;
  logic        done;
  logic        cfg_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [8:0] cap[$];
  logic upd_q    = 1'b0;
  logic rdy_q    = 1'b1;
  bit   gap_on   = 1'b0;
  bit   upd_seen = 1'b0;
  int   gap      = 0;
  int   last_gap = -1;
  int   n_xfer   = 0;
  int   acc_dly  = 0;
  int   xfer_len = 3;

  dpot_sweep_gen #(.HOLD_W(16)) dut (
    .SCLK    (SCLK),
    .rst     (rst),
    .enable  (enable),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .step    (step),
    .hold    (hold),
    .ready   (ready),
    .value   (value),
    .update  (update),
    .busy    (busy),
    .period  (period),
    .done    (done),
    .cfg_err (cfg_err)
  );

  always #5 SCLK = ~SCLK;

  // DPOT interface stand-in: accepts a request by dropping ready, stays busy
  // for xfer_len cycles, then raises ready again.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge SCLK);
      #2;
      if (ready && update && !rst) begin
        repeat (acc_dly) @(posedge SCLK);
        #2 ready = 1'b0;
        n_xfer++;
        repeat (xfer_len) @(posedge SCLK);
        #2 ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge SCLK);
      if (update && !upd_q) cap.push_back({period, value});
      if (update) upd_seen = 1'b1;
      if (ready && !rdy_q) begin
        gap    = 0;
        gap_on = 1'b1;
      end else if (gap_on) begin
        gap++;
        if (update && !upd_q) begin
          last_gap = gap;
          gap_on   = 1'b0;
        end
      end
      upd_q = update;
      rdy_q = ready;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic wait_codes(input int n);
    int t = 0;
    while (cap.size() < n && t < 2000) begin
      @(negedge SCLK);
      t++;
    end
    if (cap.size() < n) chk("tmo_codes", cap.size(), n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin
      @(negedge SCLK);
      t++;
    end
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic setup(input int m, input int l, input int h, input int s, input int hd);
    mode = 2'(m);
    lo   = 8'(l);
    hi   = 8'(h);
    step = 8'(s);
    hold = 16'(hd);
    cap.delete();
  endtask

  task automatic run_case(input int m, input int l, input int h, input int s,
                          input int hd, input int n);
    setup(m, l, h, s, hd);
    enable = 1'b1;
    wait_codes(n);
    enable = 1'b0;
    wait_idle();
  endtask

  task automatic cmp_seq(input string tag, input int ev[8], input int ep[8], input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_v%0d", tag, i), int'(cap[i][7:0]), ev[i]);
      chk($sformatf("%s_p%0d", tag, i), int'(cap[i][8]), ep[i]);
    end
  endtask

  initial begin
    int ev[8];
    int ep[8];
    int t;

    rst = 1'b1; enable = 1'b0;
    setup(0, 0, 0, 0, 0);
    tick(3);
    chk("rst_value",   int'(value),   0);
    chk("rst_update",  int'(update),  0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_period",  int'(period),  0);
    chk("rst_done",    int'(done),    0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    tick(2);

    // saw-up, with request latency checked on the first two edges
    setup(0, 10, 20, 4, 0);
    enable = 1'b1;
    tick(1);
    chk("lat_upd_e1", int'(update), 0);
    chk("lat_busy",   int'(busy),   1);
    tick(1);
    chk("lat_upd_e2", int'(update), 1);
    chk("lat_value",  int'(value),  10);
    wait_codes(7);
    enable = 1'b0;
    wait_idle();
    ev = '{10, 14, 18, 10, 14, 18, 10, 0};
    ep = '{0, 0, 0, 1, 0, 0, 1, 0};
    cmp_seq("sawup", ev, ep, 7);
    // hold=0: ready rise, XFER exit, one HOLD cycle, STEP -> update
    chk("gap_hold0", last_gap, 3);

    run_case(1, 40, 50, 3, 0, 6);
    ev = '{50, 47, 44, 41, 50, 47, 0, 0};
    ep = '{0, 0, 0, 0, 1, 0, 0, 0};
    cmp_seq("sawdn", ev, ep, 6);

    run_case(2, 0, 255, 100, 0, 8);
    ev = '{0, 100, 200, 255, 155, 55, 0, 100};
    ep = '{0, 0, 0, 0, 0, 0, 1, 0};
    cmp_seq("tri", ev, ep, 8);

    // lo==hi with step 0 (treated as 1): same code, period on every step
    run_case(0, 7, 7, 0, 0, 3);
    ev = '{7, 7, 7, 0, 0, 0, 0, 0};
    ep = '{0, 1, 1, 0, 0, 0, 0, 0};
    cmp_seq("flat", ev, ep, 3);

    // one-shot
    setup(3, 5, 9, 3, 0);
    enable = 1'b1;
    t = 0;
    while (!done && t < 500) begin
      @(negedge SCLK);
      t++;
    end
    chk("os_done", int'(done), 1);
    tick(10);
    chk("os_busy",   int'(busy),   0);
    chk("os_update", int'(update), 0);
    chk("os_ncodes", cap.size(),   3);
    ev = '{5, 8, 9, 0, 0, 0, 0, 0};
    ep = '{0, 0, 0, 0, 0, 0, 0, 0};
    cmp_seq("os", ev, ep, 3);
    enable = 1'b0;
    tick(1);
    chk("os_done_held", int'(done), 1);
    cap.delete();
    enable = 1'b1;
    tick(1);
    chk("os_done_clr", int'(done), 0);
    chk("os_re_busy",  int'(busy), 1);
    wait_codes(1);
    chk("os_re_value", int'(cap[0][7:0]), 5);
    enable = 1'b0;
    wait_idle();

    // lo > hi
    setup(0, 30, 20, 1, 0);
    upd_seen = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("cfg_load_busy", int'(busy), 1);
    tick(1);
    chk("cfg_err_set",  int'(cfg_err), 1);
    chk("cfg_busy_off", int'(busy),    0);
    tick(10);
    chk("cfg_err_hold", int'(cfg_err),  1);
    chk("cfg_busy_low", int'(busy),     0);
    chk("cfg_no_upd",   int'(upd_seen), 0);
    enable = 1'b0;
    tick(2);

    // hold=7: eight HOLD cycles plus XFER exit and STEP
    run_case(0, 10, 20, 4, 7, 4);
    chk("gap_hold7", last_gap, 10);
    ev = '{10, 14, 18, 10, 0, 0, 0, 0};
    ep = '{0, 0, 0, 1, 0, 0, 0, 0};
    cmp_seq("hold7", ev, ep, 4);

    // enable dropped while a slow interface has not yet accepted
    setup(0, 10, 20, 4, 0);
    acc_dly = 4;
    n_xfer  = 0;
    enable  = 1'b1;
    t = 0;
    while (!update && t < 50) begin
      @(negedge SCLK);
      t++;
    end
    chk("req_upd_seen", int'(update), 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("req_upd_held%0d", i), int'(update), 1);
    end
    wait_idle();
    chk("req_nxfer",  n_xfer,        1);
    chk("req_value",  int'(value),   10);
    chk("req_upd_lo", int'(update),  0);
    chk("req_ncodes", cap.size(),    1);
    acc_dly = 0;

    // asynchronous reset in the middle of a transfer
    setup(0, 10, 20, 4, 0);
    xfer_len = 6;
    enable = 1'b1;
    wait_codes(2);
    t = 0;
    while (update && t < 50) begin
      @(negedge SCLK);
      t++;
    end
    chk("pre_rst_value", int'(value), 14);
    chk("pre_rst_busy",  int'(busy),  1);
    rst = 1'b1;
    #1;
    chk("arst_value",   int'(value),   0);
    chk("arst_update",  int'(update),  0);
    chk("arst_busy",    int'(busy),    0);
    chk("arst_period",  int'(period),  0);
    chk("arst_done",    int'(done),    0);
    chk("arst_cfg_err", int'(cfg_err), 0);
    enable = 1'b0;
    tick(10);
    rst = 1'b0;
    xfer_len = 3;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
